// File: rtl/layer_serializer.sv
// layer_serializer: captures numNeuron parallel neuron outputs when every
// x_valid strobe is high in one cycle, then shifts them out one word per
// cycle to feed the next layer's serial input.
//
// Optional feature macro: LAYER_ARGMAX_EN
//   defined   -> running signed argmax over each emitted frame
//   undefined -> argmax_idx / argmax_valid tied to 0
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   x_in         in   numNeuron*dataWidth packed words, neuron k at [k*dataWidth +: dataWidth]
//   x_valid      in   per-neuron valid strobes; all high = capture
//   out_data     out  serialized word (held when out_valid is low)
//   out_valid    out  out_data qualifier
//   busy         out  high while a frame is being shifted out
//   overrun      out  one-cycle pulse when a capture is dropped
//   argmax_idx   out  index of the largest word in the last frame
//   argmax_valid out  one-cycle pulse qualifying argmax_idx
module layer_serializer #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeuron*dataWidth-1:0]  x_in,
    input  logic [numNeuron-1:0]            x_valid,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            overrun,
    output logic [$clog2(numNeuron)-1:0]    argmax_idx,
    output logic                            argmax_valid
);

    localparam int unsigned CW = $clog2(numNeuron);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [dataWidth-1:0]   mem_q [numNeuron];
    logic [dataWidth-1:0]   out_data_q;
    logic                   out_valid_q;
    logic                   overrun_q;

    logic                   capture;
    logic                   last;
    logic                   load;
    logic [CW-1:0]          cnt_inc;

    assign capture = &x_valid;
    assign last    = (cnt_q == CW'(numNeuron - 1));
    // A capture is taken when idle or on the final word of the current frame.
    assign load    = capture && ((state_q == IDLE) || last);
    assign cnt_inc = cnt_q + CW'(1);

    // Frame storage; word 0 goes straight to out_data so only 1..N-1 are read back.
    always_ff @(posedge clk) begin
        if (!rst && load) begin
            for (int k = 0; k < numNeuron; k++) begin
                mem_q[k] <= x_in[k*dataWidth +: dataWidth];
            end
        end
    end

    // Serializer FSM: out_valid is high exactly while in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (load) begin
                state_q     <= SHIFT;
                cnt_q       <= '0;
                out_data_q  <= x_in[0 +: dataWidth];
                out_valid_q <= 1'b1;
            end else if (state_q == SHIFT) begin
                if (last) begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    overrun_q  <= capture;
                    cnt_q      <= cnt_inc;
                    out_data_q <= mem_q[cnt_inc];
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;

`ifdef LAYER_ARGMAX_EN
    logic signed [dataWidth-1:0] max_q;
    logic [CW-1:0]               max_idx_q;
    logic [CW-1:0]               argmax_idx_q;
    logic                        argmax_valid_q;
    logic                        take;

    // Word 0 always seeds the maximum; strict '>' keeps the lower index on ties.
    assign take = (cnt_q == '0) || ($signed(out_data_q) > max_q);

    // Tracks the word currently on out_data; result lands the cycle after the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q          <= '0;
            max_idx_q      <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            argmax_valid_q <= 1'b0;
            if (out_valid_q) begin
                if (take) begin
                    max_q     <= $signed(out_data_q);
                    max_idx_q <= cnt_q;
                end
                if (last) begin
                    argmax_idx_q   <= take ? cnt_q : max_idx_q;
                    argmax_valid_q <= 1'b1;
                end
            end
        end
    end

    assign argmax_idx   = argmax_idx_q;
    assign argmax_valid = argmax_valid_q;
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer (numNeuron=4, dataWidth=16).
// Captured words go into a scoreboard queue; every out_valid cycle pops one.
module tb_layer_serializer;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   x_in;
    logic [N-1:0]     x_valid;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic [1:0]       argmax_idx;
    logic             argmax_valid;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q [$];

    layer_serializer #(.numNeuron(N), .dataWidth(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .x_in         (x_in),
        .x_valid      (x_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic push4(input logic [W-1:0] a, b, c, d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic expect_argmax(input logic [1:0] idx, input logic vld);
`ifdef LAYER_ARGMAX_EN
        check("argmax_valid", 32'(argmax_valid), 32'(vld));
        if (vld) check("argmax_idx", 32'(argmax_idx), 32'(idx));
`else
        check("argmax_valid_off", 32'(argmax_valid), 32'(0));
        check("argmax_idx_off", 32'(argmax_idx), 32'(0));
`endif
    endtask

    // Scoreboard: compare each emitted word against the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(out_data), 32'hDEAD_BEEF);
            end else begin
                check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        x_in    = '0;
        x_valid = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_argmax_idx", 32'(argmax_idx), 32'(0));
        check("rst_argmax_valid", 32'(argmax_valid), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single frame 5,-3,9,2
        x_in    = pack4(16'd5, 16'(-3), 16'd9, 16'd2);
        x_valid = 4'hF;
        push4(16'd5, 16'(-3), 16'd9, 16'd2);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            x_valid = '0;
            check("single_valid", 32'(out_valid), 32'(n <= 4));
            check("single_busy", 32'(busy), 32'(n <= 4));
            if (n == 5) begin
                check("single_hold", 32'(out_data), 32'(16'd2));
                expect_argmax(2'd2, 1'b1);
            end
        end

        // Partial strobe is ignored
        x_in    = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        x_valid = 4'b0111;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            x_valid = '0;
            check("partial_valid", 32'(out_valid), 32'(0));
            check("partial_busy", 32'(busy), 32'(0));
            check("partial_overrun", 32'(overrun), 32'(0));
        end

        // Overrun: second capture at +2 is dropped
        x_in    = pack4(16'd10, 16'd20, 16'd30, 16'd40);
        x_valid = 4'hF;
        push4(16'd10, 16'd20, 16'd30, 16'd40);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            x_valid = '0;
            if (n == 2) begin
                x_in    = pack4(16'd99, 16'd98, 16'd97, 16'd96);
                x_valid = 4'hF;
            end
            check("ovr_pulse", 32'(overrun), 32'(n == 3));
            check("ovr_valid", 32'(out_valid), 32'(n <= 4));
        end

        // Back-to-back frames: second capture on the last word
        x_in    = pack4(16'd100, 16'd200, 16'd300, 16'd400);
        x_valid = 4'hF;
        push4(16'd100, 16'd200, 16'd300, 16'd400);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            x_valid = '0;
            if (n == 4) begin
                x_in    = pack4(16'd1, 16'd1, 16'd1, 16'd1);
                x_valid = 4'hF;
                push4(16'd1, 16'd1, 16'd1, 16'd1);
            end
            check("b2b_valid", 32'(out_valid), 32'(n <= 8));
            check("b2b_overrun", 32'(overrun), 32'(0));
            if (n == 5) expect_argmax(2'd3, 1'b1);
            if (n == 9) expect_argmax(2'd0, 1'b1);
        end

        // Reset mid-frame aborts the frame
        x_in    = pack4(16'd7, 16'd8, 16'd9, 16'd10);
        x_valid = 4'hF;
        push4(16'd7, 16'd8, 16'd9, 16'd10);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            x_valid = '0;
            rst     = (n == 2);
            if (n >= 3) begin
                exp_q.delete();
                check("rstmid_valid", 32'(out_valid), 32'(0));
                check("rstmid_busy", 32'(busy), 32'(0));
                check("rstmid_data", 32'(out_data), 32'(0));
            end
        end

        // Reset wins over a simultaneous capture
        x_in    = pack4(16'd50, 16'd51, 16'd52, 16'd53);
        x_valid = 4'hF;
        rst     = 1'b1;
        @(negedge clk);
        x_valid = '0;
        rst     = 1'b0;
        check("rstprio_busy", 32'(busy), 32'(0));
        check("rstprio_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("rstprio_valid2", 32'(out_valid), 32'(0));

        // Replay from word 0 plus argmax tie: -1,7,7,-8
        x_in    = pack4(16'(-1), 16'd7, 16'd7, 16'(-8));
        x_valid = 4'hF;
        push4(16'(-1), 16'd7, 16'd7, 16'(-8));
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            x_valid = '0;
            check("replay_valid", 32'(out_valid), 32'(n <= 4));
            if (n <= 4) expect_argmax(2'd0, 1'b0);
            if (n == 5) expect_argmax(2'd1, 1'b1);
            if (n == 6) expect_argmax(2'd0, 1'b0);
        end

        check("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
